// File: rtl/framebuffer_ram_clr_pkg.sv
// Shared types and default sizing for the framebuffer memory and its fill engine.
package fb_pkg;

    typedef enum logic {FB_IDLE, FB_FILL} fb_state_t;

    localparam int FB_DATA_W = 8;
    localparam int FB_DEPTH  = 2048;

endpackage

// File: rtl/framebuffer_ram_clr_dpram.sv
// Plain inferred memory: one write port, two registered read ports with read-first behaviour.
module fb_dpram
    import fb_pkg::*;
#(
    parameter  int DATA_W = FB_DATA_W,
    parameter  int DEPTH  = FB_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking write above means a same-edge read sees the old word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            rdata1_q <= re1_i ? mem_q[raddr1_i] : '0;
            rdata2_q <= re2_i ? mem_q[raddr2_i] : '0;
        end
    end

    assign rdata1_o = rdata1_q;
    assign rdata2_o = rdata2_q;

endmodule

// File: rtl/framebuffer_ram_clr.sv
// Framebuffer with CPU read/write port, display read port and a one-word-per-clock fill engine.
module framebuffer_ram_clr
    import fb_pkg::*;
#(
    parameter  int DATA_W = FB_DATA_W,
    parameter  int DEPTH  = FB_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD2,
    input  logic              CLR_START,
    input  logic [DATA_W-1:0] CLR_VAL,
    output logic              BUSY,
    output logic              CLR_DONE,
    output logic              WR_DROP
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    fb_state_t         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] fill_q;
    logic              busy_q;
    logic              done_q;
    logic              drop_q;

    logic              wa1_ok;
    logic              ra2_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign wa1_ok = ({1'b0, WA1} < DEPTH_C);
    assign ra2_ok = ({1'b0, RA2} < DEPTH_C);

    // The engine owns the single write port for the whole fill.
    assign mem_we    = busy_q | (WE & wa1_ok);
    assign mem_waddr = busy_q ? ptr_q  : WA1;
    assign mem_wdata = busy_q ? fill_q : WD;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FB_IDLE;
            ptr_q   <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= WE & wa1_ok & busy_q;
            case (state_q)
                FB_IDLE: begin
                    if (CLR_START) begin
                        fill_q  <= CLR_VAL;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FB_FILL;
                    end
                end
                FB_FILL: begin
                    if (ptr_q == LAST_PTR) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FB_IDLE;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign BUSY     = busy_q;
    assign CLR_DONE = done_q;
    assign WR_DROP  = drop_q;

    fb_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i    (CLK),
        .rst_i    (RST),
        .we_i     (mem_we),
        .waddr_i  (mem_waddr),
        .wdata_i  (mem_wdata),
        .re1_i    (wa1_ok),
        .raddr1_i (WA1),
        .re2_i    (ra2_ok),
        .raddr2_i (RA2),
        .rdata1_o (RD1),
        .rdata2_o (RD2)
    );

endmodule

// File: tb/tb_framebuffer_ram_clr.sv
// Directed bench for framebuffer_ram_clr: a DEPTH=16 instance and a DEPTH=12 instance.
module tb_framebuffer_ram_clr;

    // Handshake-free design: inputs are driven after a rising edge + 1,
    // outputs compared at the same point for the edge just taken.

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       a_we, a_cs, a_busy, a_done, a_drop;
    logic [3:0] a_wa, a_ra;
    logic [7:0] a_wd, a_cv, a_rd1, a_rd2;

    logic       b_we, b_cs, b_busy, b_done, b_drop;
    logic [3:0] b_wa, b_ra;
    logic [7:0] b_wd, b_cv, b_rd1, b_rd2;

    framebuffer_ram_clr #(.DATA_W(8), .DEPTH(16)) dut_a (
        .CLK(clk), .RST(rst), .WE(a_we), .WA1(a_wa), .WD(a_wd), .RD1(a_rd1),
        .RA2(a_ra), .RD2(a_rd2), .CLR_START(a_cs), .CLR_VAL(a_cv),
        .BUSY(a_busy), .CLR_DONE(a_done), .WR_DROP(a_drop)
    );

    framebuffer_ram_clr #(.DATA_W(8), .DEPTH(12)) dut_b (
        .CLK(clk), .RST(rst), .WE(b_we), .WA1(b_wa), .WD(b_wd), .RD1(b_rd1),
        .RA2(b_ra), .RD2(b_rd2), .CLR_START(b_cs), .CLR_VAL(b_cv),
        .BUSY(b_busy), .CLR_DONE(b_done), .WR_DROP(b_drop)
    );

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [3:0] ra;
        logic [7:0] exp_rd1;
        logic [7:0] exp_rd2;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd_a(input logic [3:0] addr, input logic [7:0] exp, input string nm);
        a_wa = addr;
        a_ra = addr;
        step();
        chk($sformatf("%s_rd1[%0d]", nm, addr), {24'd0, a_rd1}, {24'd0, exp});
        chk($sformatf("%s_rd2[%0d]", nm, addr), {24'd0, a_rd2}, {24'd0, exp});
    endtask

    // Start a fill on dut_a, optionally injecting a CPU write to address 2 (inj_we)
    // and a second CLR_START with 8'h7E (inj_cs) at the given loop cycle.
    task automatic fill_a(input logic [7:0] val, input int inj_we, input int inj_cs,
                          output int busy_n, output int done_n, output int drop_n);
        busy_n = 0;
        done_n = 0;
        drop_n = 0;
        a_cs = 1'b1;
        a_cv = val;
        step();
        a_cs = 1'b0;
        if (a_busy) busy_n++;
        for (int i = 0; i < 24; i++) begin
            a_we = (i == inj_we);
            a_wa = 4'd2;
            a_wd = 8'hFF;
            a_cs = (i == inj_cs);
            if (i == inj_cs) a_cv = 8'h7E;
            step();
            if (a_busy) busy_n++;
            if (a_done) done_n++;
            if (a_drop) drop_n++;
            if (a_done && a_busy) chk("done_while_busy", 32'd1, 32'd0);
        end
        a_we = 1'b0;
        a_cs = 1'b0;
    endtask

    initial begin
        int bn, dn, pn;

        vecs[0] = '{we: 1'b1, wa: 4'd3,  wd: 8'hA5, ra: 4'd3,  exp_rd1: 8'h00, exp_rd2: 8'h00};
        vecs[1] = '{we: 1'b0, wa: 4'd3,  wd: 8'h00, ra: 4'd3,  exp_rd1: 8'hA5, exp_rd2: 8'hA5};
        vecs[2] = '{we: 1'b1, wa: 4'd5,  wd: 8'h11, ra: 4'd5,  exp_rd1: 8'h00, exp_rd2: 8'h00};
        vecs[3] = '{we: 1'b0, wa: 4'd5,  wd: 8'h00, ra: 4'd5,  exp_rd1: 8'h11, exp_rd2: 8'h11};
        vecs[4] = '{we: 1'b1, wa: 4'd0,  wd: 8'h3C, ra: 4'd15, exp_rd1: 8'h00, exp_rd2: 8'h00};
        vecs[5] = '{we: 1'b0, wa: 4'd0,  wd: 8'h00, ra: 4'd0,  exp_rd1: 8'h3C, exp_rd2: 8'h3C};
        vecs[6] = '{we: 1'b1, wa: 4'd15, wd: 8'hC3, ra: 4'd3,  exp_rd1: 8'h00, exp_rd2: 8'hA5};
        vecs[7] = '{we: 1'b0, wa: 4'd15, wd: 8'h00, ra: 4'd15, exp_rd1: 8'hC3, exp_rd2: 8'hC3};

        a_we = 0; a_wa = 0; a_wd = 0; a_ra = 0; a_cs = 0; a_cv = 0;
        b_we = 0; b_wa = 0; b_wd = 0; b_ra = 0; b_cs = 0; b_cv = 0;

        // Reset state
        repeat (2) step();
        chk("rst_rd1",  {24'd0, a_rd1}, 32'd0);
        chk("rst_rd2",  {24'd0, a_rd2}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_drop", {31'd0, a_drop}, 32'd0);
        chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Zero fill so every word has a known value
        fill_a(8'h00, -1, -1, bn, dn, pn);
        chk("zfill_busy_cycles", bn, 16);
        chk("zfill_done_pulses", dn, 1);

        // Table-driven read/write vectors
        for (int i = 0; i < 8; i++) begin
            a_we = vecs[i].we;
            a_wa = vecs[i].wa;
            a_wd = vecs[i].wd;
            a_ra = vecs[i].ra;
            step();
            chk($sformatf("vec%0d_rd1", i), {24'd0, a_rd1}, {24'd0, vecs[i].exp_rd1});
            chk($sformatf("vec%0d_rd2", i), {24'd0, a_rd2}, {24'd0, vecs[i].exp_rd2});
            chk($sformatf("vec%0d_drop", i), {31'd0, a_drop}, 32'd0);
        end
        a_we = 1'b0;

        // Fill 8'h20 with a dropped CPU write and an ignored restart
        fill_a(8'h20, 3, 6, bn, dn, pn);
        chk("fill_busy_cycles", bn, 16);
        chk("fill_done_pulses", dn, 1);
        chk("fill_drop_pulses", pn, 1);
        for (int i = 0; i < 16; i++) rd_a(4'(i), 8'h20, "fill20");

        // Distinct prior contents, then reset six cycles into a fill
        for (int i = 0; i < 16; i++) begin
            a_we = 1'b1;
            a_wa = 4'(i);
            a_wd = 8'h80 + 8'(i);
            step();
        end
        a_we = 1'b0;
        a_cs = 1'b1;
        a_cv = 8'h55;
        step();
        a_cs = 1'b0;
        repeat (6) step();
        chk("pre_rst_busy", {31'd0, a_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, a_busy}, 32'd0);
        chk("midrst_done", {31'd0, a_done}, 32'd0);
        chk("midrst_rd1",  {24'd0, a_rd1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bn = 0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_busy) bn++;
            if (a_done) dn++;
        end
        chk("post_rst_busy", bn, 0);
        chk("post_rst_done", dn, 0);
        for (int i = 0; i < 16; i++)
            rd_a(4'(i), (i < 6) ? 8'h55 : 8'h80 + 8'(i), "partial");

        // DEPTH=12: out-of-range write/read and a 12-cycle fill
        b_we = 1'b1; b_wa = 4'd13; b_wd = 8'h99;
        step();
        chk("b_oor_wr_drop", {31'd0, b_drop}, 32'd0);
        b_we = 1'b0; b_ra = 4'd13;
        step();
        chk("b_oor_rd1", {24'd0, b_rd1}, 32'd0);
        chk("b_oor_rd2", {24'd0, b_rd2}, 32'd0);
        b_cs = 1'b1; b_cv = 8'h6B;
        step();
        b_cs = 1'b0;
        bn = b_busy ? 1 : 0;
        dn = 0;
        pn = 0;
        for (int i = 0; i < 20; i++) begin
            b_we = (i == 2);
            b_wa = 4'd13;
            step();
            if (b_busy) bn++;
            if (b_done) dn++;
            if (b_drop) pn++;
        end
        b_we = 1'b0;
        chk("b_fill_busy_cycles", bn, 12);
        chk("b_fill_done_pulses", dn, 1);
        chk("b_oor_busy_drop", pn, 0);
        b_wa = 4'd11; b_ra = 4'd0;
        step();
        chk("b_rd1_last", {24'd0, b_rd1}, 32'h6B);
        chk("b_rd2_first", {24'd0, b_rd2}, 32'h6B);
        b_wa = 4'd12; b_ra = 4'd13;
        step();
        chk("b_rd1_oor12", {24'd0, b_rd1}, 32'd0);
        chk("b_rd2_oor13", {24'd0, b_rd2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
